// File: rtl/capstone_pkg.sv
// Shared definitions for the Capstone serial subtractor: controller state
// encodings and the default operand width.
package capstone_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtract_ctrl.sv
// Bit-serial A - B, LSB first. The borrow between bits lives in an external
// borrow_flipflop: bor_d feeds its D, bor_q returns the previous bit's borrow.
module serial_subtract_ctrl
   import capstone_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             CLK,
   input  logic             R,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             bor_q,
   output logic             bor_d,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int CW = $clog2(WIDTH) + 1;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic             bin;
   logic             d;
   logic             bout;
   logic             last_bit;

   // The external flop has no reset, so its value is meaningless for bit 0.
   assign bin      = (cnt == '0) ? 1'b0 : bor_q;
   assign last_bit = (cnt == CW'(WIDTH - 1));

   full_subtractor u_cell (
      .a    (sa[0]),
      .b    (sb[0]),
      .bin  (bin),
      .d    (d),
      .bout (bout)
   );

   // Forced low outside SHIFT so the external flop drains to 0 while idle.
   assign bor_d = (state == SHIFT) ? bout : 1'b0;

   // NOTE: every register here uses non-blocking assignment so all of them
   // sample the pre-edge values, matching the external flop on the same edge.
   always_ff @(posedge CLK or negedge R) begin
      if (!R) begin
         state      <= IDLE;
         cnt        <= '0;
         sa         <= '0;
         sb         <= '0;
         diff       <= '0;
         borrow_out <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  sa    <= A;
                  sb    <= B;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               sa   <= sa >> 1;
               sb   <= sb >> 1;
               diff <= {d, diff[WIDTH-1:1]};
               cnt  <= cnt + 1'b1;
               if (last_bit) begin
                  borrow_out <= bout;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  state      <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtract_ctrl.sv
// Directed bench for serial_subtract_ctrl at WIDTH=8 and WIDTH=4, each with a
// bench-side model of the external, unreset borrow flip-flop.
module tb_serial_subtract_ctrl;

   logic       CLK = 1'b0;
   logic       R;

   logic       start8;
   logic [7:0] a8, b8;
   logic       bor_q8, bor_d8, busy8, done8, borrow8;
   logic [7:0] diff8;
   logic       bor_ff8 = 1'b0;
   logic       bor_force8;

   logic       start4;
   logic [3:0] a4, b4;
   logic       bor_q4, bor_d4, busy4, done4, borrow4;
   logic [3:0] diff4;
   logic       bor_ff4 = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   // External borrow flip-flops; bor_force8 pins Q high to emulate a stale borrow.
   always @(posedge CLK) bor_ff8 <= bor_d8;
   always @(posedge CLK) bor_ff4 <= bor_d4;
   assign bor_q8 = bor_force8 ? 1'b1 : bor_ff8;
   assign bor_q4 = bor_ff4;

   serial_subtract_ctrl #(.WIDTH(8)) u_dut8 (
      .CLK        (CLK),
      .R          (R),
      .start      (start8),
      .A          (a8),
      .B          (b8),
      .bor_q      (bor_q8),
      .bor_d      (bor_d8),
      .busy       (busy8),
      .done       (done8),
      .diff       (diff8),
      .borrow_out (borrow8)
   );

   serial_subtract_ctrl #(.WIDTH(4)) u_dut4 (
      .CLK        (CLK),
      .R          (R),
      .start      (start4),
      .A          (a4),
      .B          (b4),
      .bor_q      (bor_q4),
      .bor_d      (bor_d4),
      .busy       (busy4),
      .done       (done4),
      .diff       (diff4),
      .borrow_out (borrow4)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // One WIDTH=8 operation from IDLE; optionally pins bor_q high during bit 0.
   task automatic run_op8(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_diff, input logic exp_bor,
                          input logic stale_b0);
      check("idle_bor_d", {31'd0, bor_d8}, 32'd0);
      a8     = a;
      b8     = b;
      start8 = 1'b1;
      step();                                   // edge 0
      start8     = 1'b0;
      bor_force8 = stale_b0;
      #1;
      check("bit0_bor_d", {31'd0, bor_d8}, {31'd0, (~a[0] & b[0])});
      for (int k = 1; k <= 7; k++) begin
         step();                                // edges 1..7
         bor_force8 = 1'b0;
         check("busy_mid", {31'd0, busy8}, 32'd1);
         check("done_mid", {31'd0, done8}, 32'd0);
      end
      step();                                   // edge 8
      check("done_pulse", {31'd0, done8}, 32'd1);
      check("busy_end",   {31'd0, busy8}, 32'd0);
      check("diff",       {24'd0, diff8}, {24'd0, exp_diff});
      check("borrow_out", {31'd0, borrow8}, {31'd0, exp_bor});
      step();                                   // edge 9
      check("done_clear", {31'd0, done8}, 32'd0);
      check("diff_held",  {24'd0, diff8}, {24'd0, exp_diff});
   endtask

   initial begin
      R          = 1'b0;
      start8     = 1'b0;
      start4     = 1'b0;
      a8         = '0;
      b8         = '0;
      a4         = '0;
      b4         = '0;
      bor_force8 = 1'b0;
      #2;
      check("rst_diff",   {24'd0, diff8}, 32'd0);
      check("rst_borrow", {31'd0, borrow8}, 32'd0);
      check("rst_busy",   {31'd0, busy8}, 32'd0);
      check("rst_done",   {31'd0, done8}, 32'd0);
      check("rst_bor_d",  {31'd0, bor_d8}, 32'd0);
      #10 R = 1'b1;

      run_op8(8'd200, 8'd55,  8'h91, 1'b0, 1'b0);
      run_op8(8'd55,  8'd200, 8'h6F, 1'b1, 1'b0);
      run_op8(8'd5,   8'd3,   8'h02, 1'b0, 1'b1);
      run_op8(8'd0,   8'd1,   8'hFF, 1'b1, 1'b0);
      run_op8(8'hA5,  8'hA5,  8'h00, 1'b0, 1'b0);

      // Reset mid-operation.
      a8     = 8'd200;
      b8     = 8'd55;
      start8 = 1'b1;
      step();                                   // edge 0
      start8 = 1'b0;
      repeat (4) step();                        // edges 1..4
      R = 1'b0;
      #1;
      check("mrst_diff",   {24'd0, diff8}, 32'd0);
      check("mrst_borrow", {31'd0, borrow8}, 32'd0);
      check("mrst_busy",   {31'd0, busy8}, 32'd0);
      check("mrst_done",   {31'd0, done8}, 32'd0);
      check("mrst_bor_d",  {31'd0, bor_d8}, 32'd0);
      for (int k = 0; k < 6; k++) begin
         step();
         check("mrst_no_done", {31'd0, done8}, 32'd0);
      end
      R = 1'b1;
      #2;
      run_op8(8'd9, 8'd4, 8'd5, 1'b0, 1'b0);

      // start held high for 30 edges: loads at 0, 10, 20; A/B changes during busy ignored.
      a8     = 8'd200;
      b8     = 8'd55;
      start8 = 1'b1;
      for (int n = 0; n < 30; n++) begin
         step();
         check("held_busy", {31'd0, busy8}, {31'd0, ((n % 10) < 8)});
         check("held_done", {31'd0, done8}, {31'd0, ((n % 10) == 8)});
         if (n == 8)  check("held_diff0", {24'd0, diff8}, 32'h91);
         if (n == 18) check("held_diff1", {24'd0, diff8}, 32'hFF);
         if (n == 28) check("held_diff2", {24'd0, diff8}, 32'h05);
         if (n == 3)  begin a8 = 8'd0; b8 = 8'd1; end
         if (n == 13) begin a8 = 8'd9; b8 = 8'd4; end
      end
      start8 = 1'b0;
      step();
      check("held_stop", {31'd0, busy8}, 32'd0);

      // WIDTH=4: 3 - 5 = 14 with borrow.
      a4     = 4'd3;
      b4     = 4'd5;
      start4 = 1'b1;
      step();                                   // edge 0
      start4 = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         step();
         check("w4_busy", {31'd0, busy4}, 32'd1);
      end
      step();                                   // edge 4
      check("w4_done",   {31'd0, done4}, 32'd1);
      check("w4_diff",   {28'd0, diff4}, 32'd14);
      check("w4_borrow", {31'd0, borrow4}, 32'd1);
      step();
      check("w4_done_clear", {31'd0, done4}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/serial_subtract_ctrl.md
# serial_subtract_ctrl

Bit-serial subtractor datapath and control that sits directly upstream of `borrow_flipflop` in the Capstone serial subtractor.
- Loads two WIDTH-bit operands and computes A − B LSB-first, one bit per clock.
- Drives each bit's borrow-out onto the external borrow flip-flop's D input and consumes its Q as the next bit's borrow-in.
- Assembles the difference word and final borrow, and reports completion with a start/done handshake.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- CLK  input  1  rising-edge clock, shared with `borrow_flipflop`
- R  input  1  asynchronous reset, active-low
- start  input  1  request; sampled only in IDLE
- A  input  WIDTH  minuend, captured on the start edge
- B  input  WIDTH  subtrahend, captured on the start edge
- bor_q  input  1  Q of external `borrow_flipflop` (previous bit's borrow)
- bor_d  output  1  D to external `borrow_flipflop` (current bit's borrow-out)
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse: result valid
- diff  output  WIDTH  A − B mod 2^WIDTH; held until the next accepted start
- borrow_out  output  1  final borrow (1 when A < B unsigned); held with diff

## Operation
- States:
  - IDLE: start=1 → load shift regs sa←A, sb←B; cnt←0; go to SHIFT.
  - SHIFT: each cycle processes bit cnt; after bit WIDTH−1, go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- Bit cell (SHIFT): a=sa[0], b=sb[0], bin=(cnt==0)?0:bor_q.
  - d = a^b^bin.
  - bor_d = (~a&b) | (~(a^b)&bin).
- Per SHIFT edge:
  - sa, sb shift right.
  - diff shifts right with d entering at MSB.
  - cnt+1.
  - On the last bit, borrow_out←bor_d.
- First-bit masking: bor_q is never used for bit 0. The external flop has no reset, so a stale borrow from a prior operation or power-up must not corrupt the result.
- bor_d=0 outside SHIFT, so the external flop settles to 0 when idle.
- start while busy or in DONE is ignored; no queuing.
- start held high continuously yields back-to-back operations, with one IDLE cycle between DONE and the next load.
- Arithmetic is unsigned modulo 2^WIDTH; there is no overflow flag.
- cnt is $clog2(WIDTH)+1 bits wide, so there is no wrap inside an operation.

## Timing
- Reset (R=0, asynchronous):
  - state=IDLE, cnt=0, sa=sb=0.
  - diff=0, borrow_out=0, busy=0, done=0, bor_d=0.
  - Applies at any time, including mid-SHIFT. The partial result is discarded and no done is issued.
- Release: first start is sampled on the first rising edge with R=1.
- Handshake timeline (edge 0 = start sampled in IDLE):
  - edges 1..WIDTH process bits 0..WIDTH−1.
  - busy=1 from after edge 0 until edge WIDTH.
  - done=1 from after edge WIDTH until edge WIDTH+1.
- Latency: WIDTH cycles from the start edge to done. Throughput: one result per WIDTH+2 cycles.
- bor_d is combinational from sa, sb, cnt and bor_q. The external flop captures it on the same edge the shift registers advance, so bor_q presents bit k's borrow during bit k+1.
- diff and borrow_out change only on SHIFT edges and on reset. They are stable and valid while done=1 and afterwards.

## Structure
- Shared package `capstone_pkg`: state encodings IDLE=2'b00, SHIFT=2'b01, DONE=2'b10, and the default WIDTH constant.
- Sub-module `full_subtractor` (combinational a, b, bin → d, bout) is the bit cell. It is reused by the parallel-subtractor bench.
- Top level `serial_subtract_ctrl` contains:
  - the FSM;
  - the shift registers and counter;
  - the diff/borrow_out registers.
- `borrow_flipflop` is instantiated outside this block, at the system level.

## Test plan
- WIDTH=8, A=200, B=55, start pulse → done at edge 8, diff=145 (0x91), borrow_out=0; busy high edges 1–8.
- A=55, B=200 → diff=0x6F, borrow_out=1; then A=5, B=3 with bor_q left at 1 → diff=2, borrow_out=0 (bit-0 mask).
- A=0, B=1 → diff=0xFF, borrow_out=1. Then A=B=0xA5 → diff=0x00, borrow_out=0.
- Reset mid-operation:
  - Start A=200, B=55; assert R=0 after edge 4.
  - Required: all outputs 0 immediately and no done.
  - Release, then A=9, B=4 → diff=5, borrow_out=0 at edge 8.
- start held high for 30 cycles: loads occur at edges 0, 10, 20 only. Each load gives one done pulse, and A/B changes during busy have no effect.
- WIDTH=4, A=3, B=5 → done at edge 4, diff=14, borrow_out=1.
